scan_seq_ctrl: RTL and testbench

//   Sequences the two-chain scan datapath (si1/si2 -> sdff chains -> so1/so2) through load/shift,

---
 rtl/scan_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_scan_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_seq_ctrl.sv
// Two-chain scan sequencer: loads each pattern MSB first, captures, and compares the
// previous pattern's response on so1/so2 while the next one shifts in.
module scan_seq_ctrl #(
    parameter int CHAIN_LEN = 10,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic                 pat_last,
    input  logic [CHAIN_LEN-1:0] pat_ch1,
    input  logic [CHAIN_LEN-1:0] pat_ch2,
    input  logic [CHAIN_LEN-1:0] exp_ch1,
    input  logic [CHAIN_LEN-1:0] exp_ch2,
    input  logic                 so1,
    input  logic                 so2,
    output logic                 test_mode,
    output logic                 se,
    output logic                 si1,
    output logic                 si2,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CNT_W-1:0]     pat_cnt,
    output logic [CNT_W-1:0]     mismatch_cnt
);
    localparam int MSB = CHAIN_LEN - 1;
    localparam int JW  = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(CHAIN_LEN - 1);
    localparam logic [JW-1:0] J_ONE  = JW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SHIFT  = 3'd2,
        S_CAPT   = 3'd3,
        S_UNLOAD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        if (sum[CNT_W]) sat_add = {CNT_W{1'b1}};
        else            sat_add = sum[CNT_W-1:0];
    endfunction

    state_t state_r, state_nxt_s;
    logic pat_ready_r, busy_r, done_r, test_mode_r, se_r, si1_r, si2_r, fail_r;
    logic si1_nxt_s, si2_nxt_s;
    logic [CNT_W-1:0] pat_cnt_r, mismatch_cnt_r;
    logic [CHAIN_LEN-1:0] sh1_r, sh2_r, cmp1_r, cmp2_r, nexp1_r, nexp2_r;
    logic cmp_valid_r, nexp_valid_r, last_r;
    logic [JW-1:0] j_r;
    logic start_s, accept_s, shifting_s, cmp_en_s;
    logic [1:0] diff_s;

    assign start_s    = (state_r == S_IDLE) && start && !abort;
    assign accept_s   = (state_r == S_WAIT) && pat_valid && pat_ready_r && !abort;
    assign shifting_s = (state_r == S_SHIFT) || (state_r == S_UNLOAD);
    assign cmp_en_s   = shifting_s && cmp_valid_r && !abort;
    assign diff_s     = {1'b0, so1 ^ cmp1_r[MSB]} + {1'b0, so2 ^ cmp2_r[MSB]};

    // Next-state selection; abort wins over every other transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:   if (start_s) state_nxt_s = S_WAIT; else state_nxt_s = S_IDLE;
            S_WAIT:   if (abort) state_nxt_s = S_IDLE;
                      else if (accept_s) state_nxt_s = S_SHIFT;
                      else state_nxt_s = S_WAIT;
            S_SHIFT:  if (abort) state_nxt_s = S_IDLE;
                      else if (j_r == J_LAST) state_nxt_s = S_CAPT;
                      else state_nxt_s = S_SHIFT;
            S_CAPT:   if (abort) state_nxt_s = S_IDLE;
                      else if (last_r) state_nxt_s = S_UNLOAD;
                      else state_nxt_s = S_WAIT;
            S_UNLOAD: if (abort) state_nxt_s = S_IDLE;
                      else if (j_r == J_LAST) state_nxt_s = S_DONE;
                      else state_nxt_s = S_UNLOAD;
            S_DONE:   state_nxt_s = S_IDLE;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Scan-in bit for the coming cycle: first bit straight from the pattern at accept.
    always_comb begin
        si1_nxt_s = 1'b0;
        si2_nxt_s = 1'b0;
        if (state_nxt_s == S_SHIFT) begin
            if (state_r == S_WAIT) begin
                si1_nxt_s = pat_ch1[MSB];
                si2_nxt_s = pat_ch2[MSB];
            end else begin
                si1_nxt_s = sh1_r[MSB];
                si2_nxt_s = sh2_r[MSB];
            end
        end else begin
            si1_nxt_s = 1'b0;
            si2_nxt_s = 1'b0;
        end
    end

    // State register and flopped control outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            pat_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            test_mode_r <= 1'b0;
            se_r        <= 1'b0;
            si1_r       <= 1'b0;
            si2_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pat_ready_r <= (state_nxt_s == S_WAIT);
            busy_r      <= (state_nxt_s != S_IDLE);
            done_r      <= (state_nxt_s == S_DONE);
            test_mode_r <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
            se_r        <= (state_nxt_s == S_SHIFT) || (state_nxt_s == S_UNLOAD);
            si1_r       <= si1_nxt_s;
            si2_r       <= si2_nxt_s;
        end
    end

    // Pattern/expected pipeline: the compare register always holds the previous pattern's response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh1_r        <= '0;
            sh2_r        <= '0;
            cmp1_r       <= '0;
            cmp2_r       <= '0;
            nexp1_r      <= '0;
            nexp2_r      <= '0;
            cmp_valid_r  <= 1'b0;
            nexp_valid_r <= 1'b0;
            last_r       <= 1'b0;
            j_r          <= '0;
        end else begin
            if (accept_s) begin
                sh1_r        <= {pat_ch1[MSB-1:0], 1'b0};
                sh2_r        <= {pat_ch2[MSB-1:0], 1'b0};
                cmp1_r       <= nexp1_r;
                cmp2_r       <= nexp2_r;
                cmp_valid_r  <= nexp_valid_r;
                nexp1_r      <= exp_ch1;
                nexp2_r      <= exp_ch2;
                nexp_valid_r <= 1'b1;
                last_r       <= pat_last;
            end else if ((state_r == S_CAPT) && (state_nxt_s == S_UNLOAD)) begin
                cmp1_r      <= nexp1_r;
                cmp2_r      <= nexp2_r;
                cmp_valid_r <= nexp_valid_r;
            end else if (shifting_s) begin
                sh1_r  <= {sh1_r[MSB-1:0], 1'b0};
                sh2_r  <= {sh2_r[MSB-1:0], 1'b0};
                cmp1_r <= {cmp1_r[MSB-1:0], 1'b0};
                cmp2_r <= {cmp2_r[MSB-1:0], 1'b0};
            end else if (start_s) begin
                cmp_valid_r  <= 1'b0;
                nexp_valid_r <= 1'b0;
            end
            if (shifting_s && (j_r != J_LAST)) j_r <= j_r + J_ONE;
            else                               j_r <= '0;
        end
    end

    // Session result counters: cleared on start, held through abort and DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_cnt_r      <= '0;
            mismatch_cnt_r <= '0;
            fail_r         <= 1'b0;
        end else if (start_s) begin
            pat_cnt_r      <= '0;
            mismatch_cnt_r <= '0;
            fail_r         <= 1'b0;
        end else begin
            if (cmp_en_s) begin
                mismatch_cnt_r <= sat_add(mismatch_cnt_r, diff_s);
                fail_r         <= fail_r | (diff_s != 2'd0);
            end
            if ((state_r == S_CAPT) && !abort) pat_cnt_r <= sat_add(pat_cnt_r, 2'd1);
        end
    end

    assign pat_ready    = pat_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign test_mode    = test_mode_r;
    assign se           = se_r;
    assign si1          = si1_r;
    assign si2          = si2_r;
    assign fail         = fail_r;
    assign pat_cnt      = pat_cnt_r;
    assign mismatch_cnt = mismatch_cnt_r;
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl: behavioural two-chain scan model, table-driven sessions,
// per-session result scoreboard and hand-written abort/reset/saturation sequences.
module tb_scan_seq_ctrl;
    localparam int L = 10;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic pat_valid = 1'b0, pat_last = 1'b0;
    logic [L-1:0] pat_ch1 = '0, pat_ch2 = '0, exp_ch1 = '0, exp_ch2 = '0;
    logic so1, so2;
    logic pat_ready, test_mode, se, si1, si2, busy, done, fail;
    logic [7:0] pat_cnt, mismatch_cnt;
    logic pat_ready4, test_mode4, se4, si14, si24, busy4, done4, fail4;
    logic [3:0] pat_cnt4, mismatch_cnt4;

    scan_seq_ctrl #(.CHAIN_LEN(L), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pat_valid(pat_valid),
        .pat_ready(pat_ready), .pat_last(pat_last), .pat_ch1(pat_ch1), .pat_ch2(pat_ch2),
        .exp_ch1(exp_ch1), .exp_ch2(exp_ch2), .so1(so1), .so2(so2), .test_mode(test_mode),
        .se(se), .si1(si1), .si2(si2), .busy(busy), .done(done), .fail(fail),
        .pat_cnt(pat_cnt), .mismatch_cnt(mismatch_cnt));

    scan_seq_ctrl #(.CHAIN_LEN(L), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pat_valid(pat_valid),
        .pat_ready(pat_ready4), .pat_last(pat_last), .pat_ch1(pat_ch1), .pat_ch2(pat_ch2),
        .exp_ch1(exp_ch1), .exp_ch2(exp_ch2), .so1(so1), .so2(so2), .test_mode(test_mode4),
        .se(se4), .si1(si14), .si2(si24), .busy(busy4), .done(done4), .fail(fail4),
        .pat_cnt(pat_cnt4), .mismatch_cnt(mismatch_cnt4));

    always #5 clk = ~clk;

    function automatic logic [L-1:0] fcap1(input logic [L-1:0] x);
        return x ^ 10'h155;
    endfunction
    function automatic logic [L-1:0] fcap2(input logic [L-1:0] x);
        return {x[L-2:0], x[L-1]} ^ 10'h0F0;
    endfunction
    function automatic int popcnt(input logic [L-1:0] x);
        int c = 0;
        for (int i = 0; i < L; i++) c += int'(x[i]);
        return c;
    endfunction

    // Scan chains: shift on se, one functional capture on the first se-low cycle in test mode.
    logic [L-1:0] ch1, ch2;
    logic prev_se;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch1 <= '0; ch2 <= '0; prev_se <= 1'b0;
        end else begin
            if (se) begin
                ch1 <= {ch1[L-2:0], si1};
                ch2 <= {ch2[L-2:0], si2};
            end else if (test_mode && prev_se) begin
                ch1 <= fcap1(ch1);
                ch2 <= fcap2(ch2);
            end
            prev_se <= se;
        end
    end
    assign so1 = ch1[L-1];
    assign so2 = ch2[L-1];

    // Session waveform log and first-mismatch position in se-high cycles.
    bit se_log[$];
    bit si_log[$];
    int se_hi, mm_first;
    always @(negedge clk) begin
        if (start && !busy) begin
            se_log.delete(); si_log.delete(); se_hi = 0; mm_first = 0;
        end else if (busy) begin
            se_log.push_back(se);
            si_log.push_back(si1);
            if (se) se_hi++;
            if (mismatch_cnt != 8'd0 && mm_first == 0) mm_first = se_hi;
        end
    end

    typedef struct { logic [L-1:0] p1; logic [L-1:0] p2; logic [L-1:0] f1m; logic [L-1:0] f2m; bit last; int gap; } vec_t;
    typedef struct { int first; int n; int pc; int mm; bit fl; } sess_t;
    typedef struct { int pc; int mm; bit fl; bit chk4; int pc4; int mm4; } exp_t;

    vec_t  vecs[11];
    sess_t sess[5];
    exp_t  sb[$];
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [L-1:0] p1, input logic [L-1:0] p2, input logic [L-1:0] e1,
                        input logic [L-1:0] e2, input bit last, input int gap);
        int t;
        pat_ch1 = p1; pat_ch2 = p2; exp_ch1 = e1; exp_ch2 = e2; pat_last = last;
        if (gap == 0) pat_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (pat_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            check("ready_timeout", 0, 1);
            pat_valid = 1'b0;
            return;
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_se_low", se, 0);
        end
        pat_valid = 1'b1;
        @(posedge clk); #1;
        pat_valid = 1'b0;
    endtask

    task automatic send_vec(input int i);
        send(vecs[i].p1, vecs[i].p2, fcap1(vecs[i].p1) ^ vecs[i].f1m,
             fcap2(vecs[i].p2) ^ vecs[i].f2m, vecs[i].last, vecs[i].gap);
    endtask

    task automatic finish_session();
        exp_t e;
        bit ok;
        int t;
        ok = 1'b0; t = 0;
        while (t < 1000 && !ok) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
            t++;
        end
        e = sb.pop_front();
        if (!ok) begin
            check("done_timeout", 0, 1);
        end else begin
            check("pat_cnt", pat_cnt, e.pc);
            check("mismatch_cnt", mismatch_cnt, e.mm);
            check("fail", fail, e.fl);
            if (e.chk4) begin
                check("pat_cnt_w4", pat_cnt4, e.pc4);
                check("mismatch_cnt_w4", mismatch_cnt4, e.mm4);
            end
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_done", {busy, test_mode, se}, 0);
        end
    endtask

    task automatic run_session(input int s);
        exp_t e;
        e = '{pc: sess[s].pc, mm: sess[s].mm, fl: sess[s].fl, chk4: 1'b0, pc4: 0, mm4: 0};
        sb.push_back(e);
        pulse_start();
        for (int i = sess[s].first; i < sess[s].first + sess[s].n; i++) send_vec(i);
        finish_session();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
        $fatal(1);
    end

    initial begin
        int i0, t, n, done_seen, mm8;
        bit ok_se;
        logic [L-1:0] sig, p1, p2;
        exp_t e;

        vecs[0]  = '{10'h2A5, 10'h13C, 10'h000, 10'h000, 1'b1, 0};
        vecs[1]  = '{10'h0F3, 10'h2C1, 10'h000, 10'h000, 1'b0, 0};
        vecs[2]  = '{10'h155, 10'h0AA, 10'h000, 10'h010, 1'b0, 0};
        vecs[3]  = '{10'h3C7, 10'h18E, 10'h000, 10'h000, 1'b1, 0};
        vecs[4]  = '{10'h0F3, 10'h2C1, 10'h000, 10'h000, 1'b0, 7};
        vecs[5]  = '{10'h155, 10'h0AA, 10'h000, 10'h010, 1'b0, 7};
        vecs[6]  = '{10'h3C7, 10'h18E, 10'h000, 10'h000, 1'b1, 7};
        vecs[7]  = '{10'h1B4, 10'h07F, 10'h003, 10'h000, 1'b0, 0};
        vecs[8]  = '{10'h2E2, 10'h351, 10'h000, 10'h300, 1'b1, 0};
        vecs[9]  = '{10'h111, 10'h222, 10'h000, 10'h000, 1'b0, 0};
        vecs[10] = '{10'h0AB, 10'h3F0, 10'h000, 10'h000, 1'b1, 0};
        sess[0] = '{0, 1, 1, 0, 1'b0};
        sess[1] = '{1, 3, 3, 1, 1'b1};
        sess[2] = '{4, 3, 3, 1, 1'b1};
        sess[3] = '{7, 2, 2, 4, 1'b1};
        sess[4] = '{9, 2, 2, 0, 1'b0};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {test_mode, se, si1, si2, pat_ready, busy, done, fail}, 0);
        check("rst_cnt", {pat_cnt, mismatch_cnt}, 0);
        reset = 1'b1;
        @(negedge clk);

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", {busy, test_mode}, 0);

        for (int s = 0; s < 4; s++) begin
            run_session(s);
            if (s == 0) begin
                i0 = -1;
                for (int i = 0; i < se_log.size(); i++) if (se_log[i] && i0 < 0) i0 = i;
                ok_se = 1'b1;
                sig = '0;
                if (i0 < 0 || se_log.size() < i0 + 22) ok_se = 1'b0;
                else begin
                    for (int k = 0; k < 21; k++) if (se_log[i0+k] != (k != 10)) ok_se = 1'b0;
                    if (se_log[i0+21]) ok_se = 1'b0;
                    for (int k = 0; k < L; k++) sig[L-1-k] = si_log[i0+k];
                end
                check("se_10_1_10_shape", ok_se, 1);
                check("si1_msb_first", sig, vecs[0].p1);
            end
            if (s == 1 || s == 2) check("mismatch_at_pat3_j5", mm_first, 27);
        end

        // Abort at SHIFT j=4.
        pulse_start();
        send_vec(7);
        t = 0; n = 0;
        while (n < 5 && t < 100) begin
            @(negedge clk);
            if (se) n++;
            t++;
        end
        check("abort_reach_j4", n, 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle", {busy, test_mode, se, pat_ready}, 0);
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_cnt_hold", {pat_cnt, mismatch_cnt, fail}, 0);
        run_session(4);

        // Reset asserted during CAPTURE.
        pulse_start();
        send_vec(9);
        t = 0; n = 0;
        while (t < 100 && !(n > 0 && !se)) begin
            @(negedge clk);
            if (se) n++;
            t++;
        end
        check("capture_test_mode", {busy, test_mode, se}, 3'b110);
        reset = 1'b0;
        #1;
        check("async_reset_ctrl", {test_mode, se, si1, si2, pat_ready, busy, done, fail}, 0);
        check("async_reset_cnt", {pat_cnt, mismatch_cnt, pat_cnt4, mismatch_cnt4}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Saturation: 20 patterns against all-ones expectations.
        mm8 = 0;
        for (int k = 0; k < 20; k++) begin
            p1 = 10'(k * 37 + 5);
            p2 = 10'(k * 91 + 3);
            mm8 += popcnt(~fcap1(p1)) + popcnt(~fcap2(p2));
        end
        e = '{pc: 20, mm: (mm8 > 255) ? 255 : mm8, fl: 1'b1, chk4: 1'b1, pc4: 15,
              mm4: (mm8 > 15) ? 15 : mm8};
        sb.push_back(e);
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            p1 = 10'(k * 37 + 5);
            p2 = 10'(k * 91 + 3);
            send(p1, p2, 10'h3FF, 10'h3FF, (k == 19), 0);
        end
        finish_session();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
